// File: rtl/fbrc_down_timer_if.sv
// Control/status bundle for fbrc_down_timer: load/count controls in, count and status flags out.
interface fbrc_down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, din, en, auto_reload,
    input  q, tc, busy, done
  );

  modport slave (
    input  load, din, en, auto_reload,
    output q, tc, busy, done
  );
endinterface

// File: rtl/fbrc_down_timer.sv
// Loadable down counter/timer: counts to a one-cycle terminal pulse, then stops (DONE) or
// auto-reloads from the last loaded value.
module fbrc_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  fbrc_down_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rld;
  logic             tc;
  logic             busy;
  logic             done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q     <= '0;
      rld   <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (bus.load) begin
        // A zero load parks the timer in IDLE so RUN never holds q == 0.
        q    <= bus.din;
        rld  <= bus.din;
        done <= 1'b0;
        if (bus.din != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (bus.en) begin
              if (q > ONE) begin
                q <= q - ONE;
              end else begin
                tc <= 1'b1;
                if (bus.auto_reload) begin
                  q <= rld;
                end else begin
                  q     <= '0;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end
          end
          DONE: begin
            q <= '0;
          end
          default: begin
            q <= q;
          end
        endcase
      end
    end
  end

  assign bus.q    = q;
  assign bus.tc   = tc;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_fbrc_down_timer.sv
// Directed vector bench for fbrc_down_timer: a table of per-cycle stimulus/expectation
// records plus hand-written reset and max-count sequences.
module tb_fbrc_down_timer;

  localparam int W = 4;

  logic clk;
  logic reset;

  fbrc_down_timer_if #(.WIDTH(W)) bus ();

  fbrc_down_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic [W-1:0] din;
    logic         en;
    logic         ar;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } vec_t;

  int checks;
  int failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int q, input int tc, input int busy, input int done);
    chk({tag, ".q"},    int'(bus.q),    q);
    chk({tag, ".tc"},   int'(bus.tc),   tc);
    chk({tag, ".busy"}, int'(bus.busy), busy);
    chk({tag, ".done"}, int'(bus.done), done);
  endtask

  // Drive between edges, then sample 1 time unit after the rising edge.
  task automatic step(input logic ld, input logic [W-1:0] d, input logic e, input logic ar);
    @(negedge clk);
    bus.load        = ld;
    bus.din         = d;
    bus.en          = e;
    bus.auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input int d, input logic e, input logic ar,
                              input int q, input logic tc, input logic b, input logic dn);
    vec_t v;
    v.load = ld; v.din = W'(d); v.en = e; v.ar = ar;
    v.q = W'(q); v.tc = tc; v.busy = b; v.done = dn;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    // one-shot from 5
    vecs.push_back(mk(1, 5, 1, 0, 5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    // auto-reload from 3
    vecs.push_back(mk(1, 3, 1, 1, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0));
    // enable gating from 4: en 1,0,0,1,1,1
    vecs.push_back(mk(1, 4, 1, 0, 4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
    // load beats a terminal edge; zero load goes IDLE
    vecs.push_back(mk(1, 2, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 9, 1, 0, 9, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
    // rld = 1: tc on every enabled cycle
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));

    bus.load = 1'b0; bus.din = '0; bus.en = 1'b0; bus.auto_reload = 1'b0;
    reset = 1'b0;

    // reset held low: clock and inputs toggling, outputs stay clear
    for (int i = 0; i < 4; i++) begin
      step(1'b1, W'(i + 3), 1'b1, i[0]);
      chk_out("reset_hold", 0, 0, 0, 0);
    end
    @(negedge clk);
    bus.load = 1'b0; bus.en = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].load, vecs[i].din, vecs[i].en, vecs[i].ar);
      chk_out($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].tc),
              int'(vecs[i].busy), int'(vecs[i].done));
    end

    // async reset mid-RUN, between edges
    step(1'b1, 4'd7, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk_out("pre_async", 5, 0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_clear", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b1);
    chk_out("post_reset_idle", 0, 0, 0, 0);

    // max value: 15 enabled cycles to tc, no wrap
    step(1'b1, 4'd15, 1'b1, 1'b0);
    chk_out("max_load", 15, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0);
      if (k < 15) chk_out($sformatf("max_k%0d", k), 15 - k, 0, 1, 0);
      else        chk_out("max_tc", 0, 1, 0, 1);
    end
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk_out("max_after", 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
